// File: rtl/nway_cache_control_pkg.sv
// Shared types and helpers for the N-way L2 cache controller.
package nway_cache_control_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  localparam logic ADDR_SEL_REQ    = 1'b0;
  localparam logic ADDR_SEL_VICTIM = 1'b1;
  localparam logic DATA_SEL_CPU    = 1'b0;
  localparam logic DATA_SEL_MEM    = 1'b1;

  // Sized for the largest supported associativity; callers truncate.
  function automatic logic [3:0] onehot_to_bin(input logic [15:0] oh);
    logic [3:0] b;
    b = '0;
    for (int i = 0; i < 16; i++)
      if (oh[i]) b = b | 4'(i);
    return b;
  endfunction

endpackage

// File: rtl/nway_cache_control_plru_tree.sv
// Combinational tree pseudo-LRU: victim walk and access update for one set.
module plru_tree #(
  parameter int WAYS = 4,
  parameter int LVL  = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] bits,
  input  logic [LVL-1:0]  access_way,
  output logic [WAYS-2:0] next_bits,
  output logic [LVL-1:0]  victim
);

  int node_v;
  int node_u;

  // Node k has children 2k+1 (bit 0, left) and 2k+2 (bit 1, right).
  always_comb begin
    next_bits = bits;
    victim    = '0;
    node_v    = 0;
    node_u    = 0;
    for (int l = 0; l < LVL; l++) begin
      victim[LVL-1-l] = bits[node_v];
      node_v          = 2 * node_v + 1 + int'(bits[node_v]);
    end
    for (int l = 0; l < LVL; l++) begin
      next_bits[node_u] = ~access_way[LVL-1-l];
      node_u            = 2 * node_u + 1 + int'(access_way[LVL-1-l]);
    end
  end

endmodule

// File: rtl/nway_cache_control.sv
// Write-back, write-allocate L2 controller FSM with per-set tree PLRU.
// Optional hit/miss performance counters under CACHE_PERF_CNT_EN.
module nway_cache_control
  import nway_cache_control_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int CNT_W = 32,
  parameter int WB    = $clog2(WAYS),
  parameter int SB    = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cache_read,
  input  logic            cache_write,
  input  logic [SB-1:0]   set_idx,
  input  logic [WAYS-1:0] way_hit,
  input  logic [WAYS-1:0] dirty_vec,
  input  logic            mem_resp,
  output logic            cache_resp,
  output logic            mem_read,
  output logic            mem_write,
  output logic [WB-1:0]   way_sel,
  output logic            addr_sel,
  output logic            data_sel,
  output logic [WAYS-1:0] load_data,
  output logic [WAYS-1:0] load_tag,
  output logic [WAYS-1:0] load_dirty,
  output logic            dirty_in
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
`endif
);

  state_e                    state, next_state;
  logic [SETS-1:0][WAYS-2:0] plru;
  logic [WB-1:0]             victim;
  logic                      replay;

  logic            req, is_write, hit;
  logic [WB-1:0]   hit_way, plru_vict;
  logic [WAYS-2:0] plru_next;
  logic            plru_upd, vict_ld, fill_done;
  logic [WAYS-1:0] vict_oh;

  // A simultaneous read+write is resolved as a read.
  assign req      = cache_read | cache_write;
  assign is_write = cache_write & ~cache_read;
  assign hit      = |way_hit;
  assign hit_way  = WB'(onehot_to_bin(16'(way_hit)));
  assign vict_oh  = WAYS'(1) << victim;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits       (plru[set_idx]),
    .access_way (hit_way),
    .next_bits  (plru_next),
    .victim     (plru_vict)
  );

  always_comb begin
    next_state = state;
    cache_resp = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    way_sel    = victim;
    addr_sel   = ADDR_SEL_REQ;
    data_sel   = DATA_SEL_CPU;
    load_data  = '0;
    load_tag   = '0;
    load_dirty = '0;
    dirty_in   = 1'b0;
    plru_upd   = 1'b0;
    vict_ld    = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        way_sel = hit_way;
        if (req) begin
          if (hit) begin
            cache_resp = 1'b1;
            plru_upd   = 1'b1;
            if (is_write) begin
              load_data  = way_hit;
              load_dirty = way_hit;
              dirty_in   = 1'b1;
            end
          end else begin
            vict_ld    = 1'b1;
            next_state = dirty_vec[plru_vict] ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        addr_sel  = ADDR_SEL_VICTIM;
        if (mem_resp) begin
          load_dirty = vict_oh;
          next_state = FILL;
        end
      end
      FILL: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          load_data  = vict_oh;
          load_tag   = vict_oh;
          load_dirty = vict_oh;
          data_sel   = DATA_SEL_MEM;
          fill_done  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      plru   <= '0;
      victim <= '0;
    end else begin
      state <= next_state;
      if (plru_upd) plru[set_idx] <= plru_next;
      if (vict_ld)  victim        <= plru_vict;
    end
  end

  // Replay marks the single IDLE cycle after a fill; any IDLE cycle retires it.
`ifdef CACHE_PERF_CNT_EN
  logic hit_inc, miss_inc;
  assign hit_inc  = cache_resp & ~replay;
  assign miss_inc = vict_ld;

  always_ff @(posedge clk) begin
    if (rst) begin
      replay   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state == IDLE) replay <= 1'b0;
      if (fill_done)     replay <= 1'b1;
      if (hit_inc  && !(&hit_cnt))  hit_cnt  <= hit_cnt + 1'b1;
      if (miss_inc && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      replay <= 1'b0;
    end else begin
      if (state == IDLE) replay <= 1'b0;
      if (fill_done)     replay <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nway_cache_control.sv
// Scoreboard bench for nway_cache_control (WAYS=4, SETS=8, CNT_W=4).
module tb_nway_cache_control;

  typedef struct packed {
    logic       resp, mrd, mwr;
    logic [1:0] way;
    logic       asel, dsel;
    logic [3:0] ld, lt, ldy;
    logic       din;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, cache_read, cache_write, mem_resp;
  logic [2:0] set_idx;
  logic [3:0] way_hit, dirty_vec;
  logic       cache_resp, mem_read, mem_write, addr_sel, data_sel, dirty_in;
  logic [1:0] way_sel;
  logic [3:0] load_data, load_tag, load_dirty;
`ifdef CACHE_PERF_CNT_EN
  logic [3:0] hit_cnt, miss_cnt;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  nway_cache_control #(.WAYS(4), .SETS(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cache_read(cache_read), .cache_write(cache_write),
    .set_idx(set_idx), .way_hit(way_hit), .dirty_vec(dirty_vec), .mem_resp(mem_resp),
    .cache_resp(cache_resp), .mem_read(mem_read), .mem_write(mem_write),
    .way_sel(way_sel), .addr_sel(addr_sel), .data_sel(data_sel),
    .load_data(load_data), .load_tag(load_tag), .load_dirty(load_dirty),
    .dirty_in(dirty_in)
`ifdef CACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic exp_t rh(input int w);
    exp_t e = '0;
    e.resp = 1'b1; e.way = 2'(w);
    return e;
  endfunction

  function automatic exp_t wh(input int w);
    exp_t e = '0;
    e.resp = 1'b1; e.way = 2'(w); e.ld = 4'(1 << w); e.ldy = 4'(1 << w); e.din = 1'b1;
    return e;
  endfunction

  function automatic exp_t wb(input int v, input logic mr);
    exp_t e = '0;
    e.mwr = 1'b1; e.asel = 1'b1; e.way = 2'(v);
    if (mr) e.ldy = 4'(1 << v);
    return e;
  endfunction

  function automatic exp_t fl(input int v, input logic mr);
    exp_t e = '0;
    e.mrd = 1'b1; e.way = 2'(v);
    if (mr) begin
      e.ld = 4'(1 << v); e.lt = 4'(1 << v); e.ldy = 4'(1 << v); e.dsel = 1'b1;
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic rd, input logic wr, input logic [2:0] s,
                      input logic [3:0] hv, input logic [3:0] dv, input logic mr, input exp_t e);
    rst = r; cache_read = rd; cache_write = wr; set_idx = s;
    way_hit = hv; dirty_vec = dv; mem_resp = mr;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("cache_resp", 32'(cache_resp), 32'(e.resp));
      chk("mem_read",   32'(mem_read),   32'(e.mrd));
      chk("mem_write",  32'(mem_write),  32'(e.mwr));
      chk("way_sel",    32'(way_sel),    32'(e.way));
      chk("addr_sel",   32'(addr_sel),   32'(e.asel));
      chk("data_sel",   32'(data_sel),   32'(e.dsel));
      chk("load_data",  32'(load_data),  32'(e.ld));
      chk("load_tag",   32'(load_tag),   32'(e.lt));
      chk("load_dirty", 32'(load_dirty), 32'(e.ldy));
      chk("dirty_in",   32'(dirty_in),   32'(e.din));
    end
  end

  always @(negedge clk)
    if (rst === 1'b0)
      assert (!(cache_read && cache_write)) else $error("FAIL illegal_rw: read and write together");

  initial begin
    rst = 1'b1; cache_read = 0; cache_write = 0; set_idx = 0;
    way_hit = 0; dirty_vec = 0; mem_resp = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 4'b0000, 4'b0000, 0, '0);           // reset/idle: all outputs low

    // Set 3: clean miss picks way 0, replay hit way 0
    step(0, 1, 0, 3, 4'b0000, 4'b0000, 0, '0);
    step(0, 1, 0, 3, 4'b0000, 4'b0000, 0, fl(0, 0));
    step(0, 1, 0, 3, 4'b0000, 4'b0000, 1, fl(0, 1));
    step(0, 1, 0, 3, 4'b0001, 4'b0000, 0, rh(0));
    step(0, 0, 0, 3, 4'b0000, 4'b0000, 0, '0);
    // Next miss on set 3 -> way 2, replay hit way 2
    step(0, 1, 0, 3, 4'b0000, 4'b0000, 0, '0);
    step(0, 1, 0, 3, 4'b0000, 4'b0000, 1, fl(2, 1));
    step(0, 1, 0, 3, 4'b0100, 4'b0000, 0, rh(2));
    // Write miss, clean victim way 1, replay merges the write
    step(0, 0, 1, 3, 4'b0000, 4'b0000, 0, '0);
    step(0, 0, 1, 3, 4'b0000, 4'b0000, 0, fl(1, 0));
    step(0, 0, 1, 3, 4'b0000, 4'b0000, 1, fl(1, 1));
    step(0, 0, 1, 3, 4'b0010, 4'b0000, 0, wh(1));
`ifdef CACHE_PERF_CNT_EN
    chk("hit_cnt_a",  32'(hit_cnt), 0);
    chk("miss_cnt_a", 32'(miss_cnt), 3);
`endif
    // Write hit way 3
    step(0, 0, 1, 3, 4'b1000, 4'b1000, 0, wh(3));

    // Set 5: hit way 0 so the victim becomes way 2, then dirty read miss
    step(0, 1, 0, 5, 4'b0001, 4'b0000, 0, rh(0));
    step(0, 1, 0, 5, 4'b0000, 4'b0100, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 5, 4'b0000, 4'b0100, 0, wb(2, 0));
    step(0, 1, 0, 5, 4'b0000, 4'b0100, 1, wb(2, 1));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 5, 4'b0000, 4'b0000, 0, fl(2, 0));
    step(0, 1, 0, 5, 4'b0000, 4'b0000, 1, fl(2, 1));
    step(0, 1, 0, 5, 4'b0100, 4'b0000, 0, rh(2));
`ifdef CACHE_PERF_CNT_EN
    chk("hit_cnt_b",  32'(hit_cnt), 2);
    chk("miss_cnt_b", 32'(miss_cnt), 4);
`endif

    // Reset in the second FILL cycle; later mem_resp is ignored
    step(0, 1, 0, 6, 4'b0000, 4'b0000, 0, '0);
    step(0, 1, 0, 6, 4'b0000, 4'b0000, 0, fl(0, 0));
    step(1, 1, 0, 6, 4'b0000, 4'b0000, 0, fl(0, 0));
    step(0, 0, 0, 6, 4'b0000, 4'b0000, 1, '0);
    step(0, 0, 0, 6, 4'b0000, 4'b0000, 0, '0);
    // Set 5 PLRU was cleared: victim back to way 0
    step(0, 1, 0, 5, 4'b0000, 4'b0000, 0, '0);
    step(0, 1, 0, 5, 4'b0000, 4'b0000, 1, fl(0, 1));
    step(0, 1, 0, 5, 4'b0001, 4'b0000, 0, rh(0));
`ifdef CACHE_PERF_CNT_EN
    chk("hit_cnt_c",  32'(hit_cnt), 0);
    chk("miss_cnt_c", 32'(miss_cnt), 1);
`endif

    // Request dropped mid-fill: fill completes, no response
    step(0, 1, 0, 7, 4'b0000, 4'b0000, 0, '0);
    step(0, 0, 0, 7, 4'b0000, 4'b0000, 0, fl(0, 0));
    step(0, 0, 0, 7, 4'b0000, 4'b0000, 1, fl(0, 1));
    step(0, 0, 0, 7, 4'b0000, 4'b0000, 0, '0);

    // 20 read hits: 4-bit hit counter saturates
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 4'b0010, 4'b0000, 0, rh(1));
    step(0, 0, 0, 0, 4'b0000, 4'b0000, 0, '0);
`ifdef CACHE_PERF_CNT_EN
    chk("hit_cnt_sat", 32'(hit_cnt), 15);
    chk("miss_cnt_d",  32'(miss_cnt), 2);
`endif

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
